// File: rtl/exc_addr_unit.sv
// exc_addr_unit: registered address source select with prioritised exception vectoring.
// Requests are sticky until served; epc is captured only when leaving IDLE.
module exc_addr_unit #(
    parameter int WIDTH        = 32,
    parameter int VEC_NOT_OP   = 253,
    parameter int VEC_OVERFLOW = 254,
    parameter int VEC_DIVBY0   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       seletor,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] rt,
    input  logic [WIDTH-1:0] rs,
    input  logic             exc_not_op,
    input  logic             exc_overflow,
    input  logic             exc_div0,
    input  logic             exc_ready,
    output logic [WIDTH-1:0] saida,
    output logic             exc_valid,
    output logic [1:0]       exc_cause,
    output logic [WIDTH-1:0] epc,
    output logic             exc_busy
);
    typedef enum logic {IDLE, VEC} state_t;

    localparam logic [WIDTH-1:0] V_NOT_OP = WIDTH'(VEC_NOT_OP);
    localparam logic [WIDTH-1:0] V_OVF    = WIDTH'(VEC_OVERFLOW);
    localparam logic [WIDTH-1:0] V_DIV0   = WIDTH'(VEC_DIVBY0);

    state_t           state_q, state_d;
    logic [2:0]       pend_q, pend_d;
    logic [WIDTH-1:0] saida_q, saida_d;
    logic [1:0]       cause_q, cause_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [2:0]       req, clr, rem;
    logic [WIDTH-1:0] sel_addr;
    logic [1:0]       top_cause;

    assign req = {exc_div0, exc_overflow, exc_not_op};

    // only the vector currently presented can be cleared, and only while in VEC
    assign clr = (state_q == VEC && exc_ready) ?
                 (cause_q == 2'd1 ? 3'b001 : cause_q == 2'd2 ? 3'b010 : cause_q == 2'd3 ? 3'b100 : 3'b000) :
                 3'b000;
    assign rem = (pend_q & ~clr) | req;

    assign top_cause = rem[0] ? 2'd1 : rem[1] ? 2'd2 : rem[2] ? 2'd3 : 2'd0;

    assign sel_addr = seletor == 4'd0 ? pc :
                      seletor == 4'd2 ? alu_result :
                      seletor == 4'd3 ? rt :
                      seletor == 4'd4 ? rs :
                      seletor == 4'd6 ? V_NOT_OP :
                      seletor == 4'd7 ? V_OVF : V_DIV0;

    always_comb begin
        state_d = state_q;
        pend_d  = rem;
        saida_d = saida_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        if (state_q == IDLE || exc_ready) begin
            if (rem != 3'b000) begin
                state_d = VEC;
                cause_d = top_cause;
                saida_d = top_cause == 2'd1 ? V_NOT_OP : top_cause == 2'd2 ? V_OVF : V_DIV0;
                epc_d   = state_q == IDLE ? pc : epc_q;
            end else begin
                state_d = IDLE;
                cause_d = 2'd0;
                saida_d = sel_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            saida_q <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            saida_q <= saida_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    assign saida     = saida_q;
    assign exc_valid = state_q == VEC;
    assign exc_cause = cause_q;
    assign epc       = epc_q;
    assign exc_busy  = (state_q == VEC) | (pend_q != 3'b000);
endmodule

// File: tb/tb_exc_addr_unit.sv
// tb_exc_addr_unit: directed checks of select muxing, exception vectoring and reset.
module tb_exc_addr_unit;
    logic        clk = 1'b0;
    logic        reset, exc_not_op, exc_overflow, exc_div0, exc_ready;
    logic [3:0]  seletor;
    logic [31:0] pc, alu_result, rt, rs;
    logic [31:0] saida, epc;
    logic        exc_valid, exc_busy;
    logic [1:0]  exc_cause;
    logic [15:0] saida16, epc16;
    logic        valid16, busy16;
    logic [1:0]  cause16;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    exc_addr_unit dut (
        .clk(clk), .reset(reset), .seletor(seletor), .pc(pc), .alu_result(alu_result),
        .rt(rt), .rs(rs), .exc_not_op(exc_not_op), .exc_overflow(exc_overflow),
        .exc_div0(exc_div0), .exc_ready(exc_ready), .saida(saida), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .epc(epc), .exc_busy(exc_busy)
    );

    exc_addr_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .seletor(seletor), .pc(pc[15:0]), .alu_result(alu_result[15:0]),
        .rt(rt[15:0]), .rs(rs[15:0]), .exc_not_op(exc_not_op), .exc_overflow(exc_overflow),
        .exc_div0(exc_div0), .exc_ready(exc_ready), .saida(saida16), .exc_valid(valid16),
        .exc_cause(cause16), .epc(epc16), .exc_busy(busy16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; seletor = 4'd0; pc = 32'h0; alu_result = 32'h0; rt = 32'h0; rs = 32'h0;
        exc_not_op = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0; exc_ready = 1'b0;
        step;
        chk("rst_saida", saida, 32'h0);
        chk("rst_valid", 32'(exc_valid), 32'h0);
        chk("rst_cause", 32'(exc_cause), 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_busy", 32'(exc_busy), 32'h0);

        reset = 1'b1; seletor = 4'd2; alu_result = 32'h1234; rt = 32'hDEAD_BEEF; rs = 32'hCAFE_0001; pc = 32'h10;
        step;
        chk("sel2_saida", saida, 32'h1234);
        chk("sel2_valid", 32'(exc_valid), 32'h0);
        seletor = 4'd3; step; chk("sel3_saida", saida, 32'hDEAD_BEEF);
        seletor = 4'd4; step; chk("sel4_saida", saida, 32'hCAFE_0001);
        seletor = 4'd0; step; chk("sel0_saida", saida, 32'h10);
        seletor = 4'd6; step; chk("sel6_saida", saida, 32'hFD);
        seletor = 4'd7; step; chk("sel7_saida", saida, 32'hFE);
        seletor = 4'd5; step;
        chk("sel5_saida", saida, 32'hFF);
        chk("sel5_valid", 32'(exc_valid), 32'h0);
        chk("sel5_w16", 32'(saida16), 32'h0000_00FF);

        // single overflow pulse; seletor must be ignored on entry
        seletor = 4'd2; pc = 32'h40; exc_overflow = 1'b1; step;
        chk("ovf_saida", saida, 32'hFE);
        chk("ovf_cause", 32'(exc_cause), 32'd2);
        chk("ovf_epc", epc, 32'h40);
        chk("ovf_valid", 32'(exc_valid), 32'h1);
        chk("ovf_busy", 32'(exc_busy), 32'h1);
        chk("ovf_w16", 32'(saida16), 32'h0000_00FE);
        exc_overflow = 1'b0; pc = 32'h44; step;
        chk("ovf_hold_saida", saida, 32'hFE);
        chk("ovf_hold_valid", 32'(exc_valid), 32'h1);
        chk("ovf_hold_epc", epc, 32'h40);
        exc_ready = 1'b1; step;
        chk("ovf_done_valid", 32'(exc_valid), 32'h0);
        chk("ovf_done_cause", 32'(exc_cause), 32'h0);
        chk("ovf_done_saida", saida, 32'h1234);
        chk("ovf_done_busy", 32'(exc_busy), 32'h0);
        step;
        chk("idle_ready_valid", 32'(exc_valid), 32'h0);
        chk("idle_ready_saida", saida, 32'h1234);
        exc_ready = 1'b0;

        // simultaneous not_op and div0
        pc = 32'h50; exc_not_op = 1'b1; exc_div0 = 1'b1; step;
        chk("dual1_saida", saida, 32'hFD);
        chk("dual1_cause", 32'(exc_cause), 32'd1);
        chk("dual1_epc", epc, 32'h50);
        exc_not_op = 1'b0; exc_div0 = 1'b0; pc = 32'h60; exc_ready = 1'b1; step;
        chk("dual2_saida", saida, 32'hFF);
        chk("dual2_cause", 32'(exc_cause), 32'd3);
        chk("dual2_valid", 32'(exc_valid), 32'h1);
        chk("dual2_epc", epc, 32'h50);
        step;
        chk("dual3_valid", 32'(exc_valid), 32'h0);
        chk("dual3_cause", 32'(exc_cause), 32'h0);
        chk("dual3_saida", saida, 32'h1234);
        exc_ready = 1'b0;

        // set wins over clear for the served bit
        exc_overflow = 1'b1; step;
        chk("sw_enter_cause", 32'(exc_cause), 32'd2);
        exc_ready = 1'b1; step;
        chk("sw_valid", 32'(exc_valid), 32'h1);
        chk("sw_saida", saida, 32'hFE);
        chk("sw_cause", 32'(exc_cause), 32'd2);
        exc_overflow = 1'b0; step;
        chk("sw_done_valid", 32'(exc_valid), 32'h0);
        exc_ready = 1'b0;

        // reset mid-VEC with a request still asserted
        exc_div0 = 1'b1; step;
        chk("rv_enter_saida", saida, 32'hFF);
        exc_div0 = 1'b0; exc_not_op = 1'b1; reset = 1'b0; step;
        chk("rv_saida", saida, 32'h0);
        chk("rv_valid", 32'(exc_valid), 32'h0);
        chk("rv_cause", 32'(exc_cause), 32'h0);
        chk("rv_epc", epc, 32'h0);
        chk("rv_busy", 32'(exc_busy), 32'h0);
        exc_not_op = 1'b0; reset = 1'b1; seletor = 4'd0; pc = 32'h80; step;
        chk("rv_after_saida", saida, 32'h80);
        chk("rv_after_valid", 32'(exc_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
